// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction-fetch front end.
package fetch_pkg;

  localparam int INST_W          = 32;
  localparam int ADDR_W          = 32;
  localparam int FETCH_BUF_DEPTH = 2;
  localparam int CNT_W           = $clog2(FETCH_BUF_DEPTH + 1);

  // One fetched instruction together with the address it came from.
  typedef struct packed {
    logic [ADDR_W-1:0] pc;
    logic [INST_W-1:0] inst;
  } fetch_entry_t;

  localparam int ENTRY_W = $bits(fetch_entry_t);

  // Front-end state, decoded from buffer occupancy and the fault flag.
  typedef enum logic [1:0] {
    ST_EMPTY,
    ST_ONE,
    ST_FULL,
    ST_HALT
  } fetch_state_t;

  // A fetch address is bad when it is not word aligned or lies past the memory.
  function automatic logic addr_bad(input logic [ADDR_W-1:0] addr,
                                    input logic [ADDR_W:0]   limit);
    return (addr[1:0] != 2'b00) || ({1'b0, addr} >= limit);
  endfunction

endpackage

// File: rtl/fetch_buf.sv
// Two-entry FIFO of {pc, inst} pairs between the fetch stage and decode.
// Flush wins over push; a pop on an empty buffer is ignored.
module fetch_buf
  import fetch_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic             pop,
  input  logic             flush,
  input  fetch_entry_t     din,
  output logic [CNT_W-1:0] count,
  output fetch_entry_t     head,
  output logic             full
);

  logic [CNT_W-1:0]   count_q;
  logic [ENTRY_W-1:0] head_q;
  logic [ENTRY_W-1:0] tail_q;
  logic               do_pop;
  logic               do_push;

  assign full    = (count_q == CNT_W'(FETCH_BUF_DEPTH));
  assign do_pop  = pop && (count_q != '0);
  assign do_push = push && (!full || do_pop);

  // Occupancy and slot update: head slot always holds the oldest entry.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      // NOTE: the data slots are reset too because out_pc/out_inst have a defined reset value.
      count_q <= '0;
      head_q  <= '0;
      tail_q  <= '0;
    end else if (flush) begin
      count_q <= '0;
    end else begin
      // NOTE: non-blocking assignments let head_q take the old tail_q in the same edge that tail_q is rewritten.
      case ({do_push, do_pop})
        2'b10: begin
          if (count_q == '0) head_q <= din;
          else               tail_q <= din;
          count_q <= count_q + CNT_W'(1);
        end
        2'b01: begin
          head_q  <= tail_q;
          count_q <= count_q - CNT_W'(1);
        end
        2'b11: begin
          if (count_q == CNT_W'(1)) begin
            head_q <= din;
          end else begin
            head_q <= tail_q;
            tail_q <= din;
          end
        end
        default: ;
      endcase
    end
  end

  assign count = count_q;
  assign head  = fetch_entry_t'(head_q);

endmodule

// File: rtl/inst_fetch.sv
// Instruction-fetch front end: PC register, fetch enable, fault tracking and
// a two-entry buffer presenting a valid/ready instruction stream to decode.
module inst_fetch
  import fetch_pkg::*;
#(
  parameter logic [ADDR_W-1:0] RESET_PC   = 32'h0000_0000,
  parameter int                IMEM_DEPTH = 256
) (
  input  logic              clk,
  input  logic              rst_n,
  output logic [ADDR_W-1:0] pc_out,
  input  logic [INST_W-1:0] ir,
  input  logic              redirect_valid,
  input  logic [ADDR_W-1:0] redirect_target,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [ADDR_W-1:0] out_pc,
  output logic [INST_W-1:0] out_inst,
  output logic              fault
);

  // First byte address past the instruction memory.
  localparam logic [ADDR_W:0] PC_LIMIT = (ADDR_W + 1)'(IMEM_DEPTH) * (ADDR_W + 1)'(4);

  logic [ADDR_W-1:0] pc_q;
  logic [ADDR_W-1:0] pc_next;
  logic              fault_q;
  logic [CNT_W-1:0]  buf_count;
  logic              buf_full;
  fetch_entry_t      buf_head;
  fetch_entry_t      fetch_entry;
  fetch_state_t      state;
  logic              pop;
  logic              fetch_en;

  assign pc_next     = pc_q + ADDR_W'(4);
  assign pop         = out_valid && out_ready;
  assign fetch_entry = '{pc: pc_q, inst: ir};

  // State decode and fetch enable; the state itself lives in count and fault.
  always_comb begin
    // NOTE: every output of this block gets a default first so no path leaves it holding a value (no latch).
    state    = ST_ONE;
    fetch_en = 1'b0;
    if (fault_q)                state = ST_HALT;
    else if (buf_full)          state = ST_FULL;
    else if (buf_count == '0)   state = ST_EMPTY;
    if (!redirect_valid) begin
      case (state)
        ST_EMPTY, ST_ONE: fetch_en = 1'b1;
        ST_FULL:          fetch_en = pop;
        default:          fetch_en = 1'b0;
      endcase
    end
  end

  // PC and sticky fault: redirect first, then sequential advance.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q    <= RESET_PC;
      fault_q <= 1'b0;
    end else if (redirect_valid) begin
      pc_q    <= redirect_target;
      fault_q <= addr_bad(redirect_target, PC_LIMIT);
    end else if (fetch_en) begin
      pc_q <= pc_next;
      if ({1'b0, pc_next} >= PC_LIMIT) fault_q <= 1'b1;
    end
  end

  fetch_buf u_buf (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (fetch_en),
    .pop   (pop),
    .flush (redirect_valid),
    .din   (fetch_entry),
    .count (buf_count),
    .head  (buf_head),
    .full  (buf_full)
  );

  assign pc_out    = pc_q;
  assign fault     = fault_q;
  assign out_valid = (buf_count != '0);
  assign out_pc    = buf_head.pc;
  assign out_inst  = buf_head.inst;

endmodule

// File: tb/tb_inst_fetch.sv
// Randomised scoreboard bench for inst_fetch with a transaction-level model.
module tb_inst_fetch;

  localparam int          DEPTH = 256;
  localparam logic [31:0] LIMIT = 32'(DEPTH * 4);

  logic        clk;
  logic        rst_n;
  logic [31:0] pc_out;
  logic [31:0] ir;
  logic        redirect_valid;
  logic [31:0] redirect_target;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_pc;
  logic [31:0] out_inst;
  logic        fault;

  inst_fetch #(.RESET_PC(32'h0), .IMEM_DEPTH(DEPTH)) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .pc_out          (pc_out),
    .ir              (ir),
    .redirect_valid  (redirect_valid),
    .redirect_target (redirect_target),
    .out_valid       (out_valid),
    .out_ready       (out_ready),
    .out_pc          (out_pc),
    .out_inst        (out_inst),
    .fault           (fault)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Instruction memory, combinational read.
  logic [31:0] mem [DEPTH];
  always_comb ir = mem[pc_out[9:2]];

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
  } ent_t;

  typedef struct packed {
    logic [31:0] pc;
    logic        fault;
    logic        valid;
  } cyc_t;

  // Model state: buffered pairs, next fetch address, halted flag.
  ent_t        m_buf [$];
  logic [31:0] m_pc;
  bit          m_fault;

  ent_t acc_q [$];
  cyc_t cyc_q [$];

  int n_checks = 0;
  int n_errors = 0;
  int n_accepts = 0;
  bit mon_en = 1'b0;

  task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
    n_checks++;
    if (actual !== expected) begin
      n_errors++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, actual, expected, $time);
    end
  endtask

  task automatic model_reset();
    m_buf.delete();
    acc_q.delete();
    cyc_q.delete();
    m_pc    = 32'h0;
    m_fault = 1'b0;
  endtask

  // Advance the model across one clock edge given that edge's inputs.
  task automatic model_step(input bit rdy, input bit rv, input logic [31:0] tgt);
    bit pop;
    bit room;
    cyc_q.push_back('{pc: m_pc, fault: m_fault, valid: (m_buf.size() > 0)});
    pop = (m_buf.size() > 0) && rdy;
    if (pop) acc_q.push_back(m_buf[0]);
    if (rv) begin
      m_buf.delete();
      m_pc    = tgt;
      m_fault = (tgt % 4 != 0) || (tgt >= LIMIT);
    end else begin
      room = m_buf.size() < 2;
      if (pop) void'(m_buf.pop_front());
      if (!m_fault && (room || pop)) begin
        m_buf.push_back('{pc: m_pc, inst: mem[m_pc / 4]});
        m_pc = m_pc + 4;
        if (m_pc >= LIMIT) m_fault = 1'b1;
      end
    end
  endtask

  task automatic apply(input bit rdy, input bit rv, input logic [31:0] tgt);
    out_ready       = rdy;
    redirect_valid  = rv;
    redirect_target = tgt;
    #1;
    model_step(rdy, rv, tgt);
  endtask

  task automatic cycle(input bit rdy, input bit rv, input logic [31:0] tgt);
    @(negedge clk);
    apply(rdy, rv, tgt);
  endtask

  task automatic release_reset();
    @(negedge clk);
    rst_n  = 1'b1;
    mon_en = 1'b1;
    apply(1'b1, 1'b0, 32'h0);
  endtask

  // Asynchronous reset in the middle of a low clock phase.
  task automatic mid_reset();
    @(negedge clk);
    mon_en = 1'b0;
    #3;
    rst_n = 1'b0;
    #1;
    check("rst_out_valid", out_valid, 1'b0);
    check("rst_pc_out", pc_out, 32'h0);
    check("rst_fault", fault, 1'b0);
    check("rst_out_pc", out_pc, 32'h0);
    check("rst_out_inst", out_inst, 32'h0);
    model_reset();
    repeat (2) @(negedge clk);
    release_reset();
  endtask

  function automatic logic [31:0] rand_target();
    int sel;
    sel = $urandom_range(0, 99);
    if (sel < 60)      return 32'($urandom_range(0, DEPTH - 1)) * 4;
    else if (sel < 75) return 32'($urandom_range(DEPTH - 4, DEPTH - 1)) * 4;
    else if (sel < 90) return (32'($urandom_range(0, DEPTH - 1)) * 4) | 32'($urandom_range(1, 3));
    else               return LIMIT + (32'($urandom_range(0, 1000)) * 4);
  endfunction

  // Monitor: compares per-cycle state and every completed handshake.
  initial begin
    cyc_t c;
    ent_t e;
    forever begin
      @(negedge clk);
      #2;
      if (mon_en) begin
        if (cyc_q.size() == 0) begin
          check("cyc_underflow", 32'd0, 32'd1);
        end else begin
          c = cyc_q.pop_front();
          check("out_valid", out_valid, c.valid);
          check("pc_out", pc_out, c.pc);
          check("fault", fault, c.fault);
        end
        if (out_valid && out_ready) begin
          n_accepts++;
          if (acc_q.size() == 0) begin
            check("acc_underflow", 32'd0, 32'd1);
          end else begin
            e = acc_q.pop_front();
            check("out_pc", out_pc, e.pc);
            check("out_inst", out_inst, e.inst);
          end
        end
      end
    end
  end

  // Stimulus: directed scenarios followed by random traffic.
  initial begin
    logic [31:0] tgt;
    bit          rv;
    for (int i = 0; i < DEPTH; i++) mem[i] = {16'($urandom), 16'(i)};
    rst_n           = 1'b0;
    out_ready       = 1'b0;
    redirect_valid  = 1'b0;
    redirect_target = 32'h0;
    model_reset();
    #2;
    check("init_out_valid", out_valid, 1'b0);
    check("init_pc_out", pc_out, 32'h0);
    check("init_fault", fault, 1'b0);
    check("init_out_pc", out_pc, 32'h0);
    check("init_out_inst", out_inst, 32'h0);
    repeat (2) @(negedge clk);
    release_reset();

    // Streaming, then back-pressure and drain.
    repeat (4) cycle(1'b1, 1'b0, 32'h0);
    repeat (5) cycle(1'b0, 1'b0, 32'h0);
    repeat (4) cycle(1'b1, 1'b0, 32'h0);

    // Redirect while full with decode accepting.
    repeat (3) cycle(1'b0, 1'b0, 32'h0);
    cycle(1'b1, 1'b1, 32'h40);
    repeat (4) cycle(1'b1, 1'b0, 32'h0);

    // Misaligned redirect faults; a good redirect recovers.
    cycle(1'b0, 1'b1, 32'h42);
    repeat (3) cycle(1'b1, 1'b0, 32'h0);
    cycle(1'b1, 1'b1, 32'h10);
    repeat (4) cycle(1'b1, 1'b0, 32'h0);

    // Run off the end of memory, then redirect past it, then recover.
    cycle(1'b1, 1'b1, LIMIT - 32'h10);
    repeat (8) cycle(1'b1, 1'b0, 32'h0);
    cycle(1'b1, 1'b1, LIMIT);
    repeat (3) cycle(1'b1, 1'b0, 32'h0);
    cycle(1'b1, 1'b1, LIMIT - 32'h4);
    repeat (4) cycle(1'b0, 1'b0, 32'h0);
    repeat (3) cycle(1'b1, 1'b0, 32'h0);
    cycle(1'b1, 1'b1, 32'h0);
    repeat (3) cycle(1'b1, 1'b0, 32'h0);

    // Reset with the buffer full, then restart.
    repeat (3) cycle(1'b0, 1'b0, 32'h0);
    mid_reset();
    repeat (4) cycle(1'b1, 1'b0, 32'h0);

    // Random traffic.
    for (int n = 0; n < 2000; n++) begin
      rv  = ($urandom_range(0, 99) < (m_fault ? 30 : 6));
      tgt = rand_target();
      cycle($urandom_range(0, 99) < 70, rv, tgt);
      if (n == 1000) mid_reset();
    end

    repeat (6) cycle(1'b1, 1'b0, 32'h0);
    #2;
    check("acc_q_drained", 32'(acc_q.size()), 32'd0);
    check("handshakes_seen", 32'(n_accepts > 100), 32'd1);
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
